// File: rtl/sp_ram_fifo_ctrl_if.sv
// Signal bundle between the FIFO controller, its push/pop streams and the single-port RAM.
// The slave side is the controller; the master side is whoever drives streams and RAM data.
interface sp_ram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
);
    logic                  wr_vld;
    logic                  wr_rdy;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic                  rd_vld;
    logic                  rd_rdy;
    logic [DATA_WIDTH-1:0] rd_dat;
    logic [ADDR_WIDTH+1:0] count;
    logic [ADDR_WIDTH-1:0] ram_addr_r;
    logic [ADDR_WIDTH-1:0] ram_addr_w;
    logic                  ram_read_en;
    logic                  ram_write_en;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic [DATA_WIDTH-1:0] ram_data_out;

    modport master (
        output wr_vld, wr_dat, rd_rdy, ram_data_out,
        input  wr_rdy, rd_vld, rd_dat, count,
        input  ram_addr_r, ram_addr_w, ram_read_en, ram_write_en, ram_data_in
    );

    modport slave (
        input  wr_vld, wr_dat, rd_rdy, ram_data_out,
        output wr_rdy, rd_vld, rd_dat, count,
        output ram_addr_r, ram_addr_w, ram_read_en, ram_write_en, ram_data_in
    );
endinterface

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller over a single-port SRAM: one RAM access per cycle, read latency
// absorbed by a 2-entry skid buffer, giving DEPTH + 2 words of storage.
module sp_ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst_n,
    sp_ram_fifo_ctrl_if.slave bus
);
    localparam logic [ADDR_WIDTH:0]   RAM_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0]             wptr, rptr;
    logic [ADDR_WIDTH:0]               ram_cnt;
    logic                              inflight;
    logic [1:0][DATA_WIDTH-1:0]        skid;
    logic                              head, tail;
    logic [1:0]                        out_cnt;

    logic [1:0] occ;
    logic       room, starve, full;
    logic       wen, ren, pop;

    // Words already committed to the output side (held or on their way from the RAM).
    assign occ    = out_cnt + {1'b0, inflight};
    assign room   = occ < 2'd2;
    assign starve = (ram_cnt != '0) && (occ == 2'd0);
    assign full   = (ram_cnt == RAM_FULL);

    assign wen = bus.wr_vld && bus.wr_rdy;
    assign ren = (ram_cnt != '0) && room && !wen;
    assign pop = bus.rd_vld && bus.rd_rdy;

    assign bus.wr_rdy       = !full && !starve;
    assign bus.ram_write_en = wen;
    assign bus.ram_read_en  = ren;
    assign bus.ram_addr_w   = wptr;
    assign bus.ram_addr_r   = rptr;
    assign bus.ram_data_in  = bus.wr_dat;
    assign bus.rd_vld       = (out_cnt != 2'd0);
    assign bus.rd_dat       = skid[head];
    assign bus.count        = (ADDR_WIDTH+2)'(ram_cnt) + (ADDR_WIDTH+2)'(occ);

    // NOTE: all state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            out_cnt  <= 2'd0;
            head     <= 1'b0;
            tail     <= 1'b0;
            // NOTE: the two skid words are reset so rd_dat reads 0; the RAM array is never reset.
            skid     <= '0;
        end else begin
            inflight <= ren;
            if (wen) wptr <= wptr + PTR_ONE;
            if (ren) rptr <= rptr + PTR_ONE;

            case ({wen, ren})
                2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
                2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
                default: ram_cnt <= ram_cnt;
            endcase

            // A read is only issued when the skid has room, so this push never overflows.
            if (inflight) begin
                skid[tail] <= bus.ram_data_out;
                tail       <= ~tail;
            end
            if (pop) head <= ~head;

            case ({inflight, pop})
                2'b10:   out_cnt <= out_cnt + 2'd1;
                2'b01:   out_cnt <= out_cnt - 2'd1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Bench for sp_ram_fifo_ctrl with DEPTH = 4: directed scenarios plus random traffic,
// checked against a word-queue model of the FIFO and a behavioural RAM.
module tb_sp_ram_fifo_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sp_ram_fifo_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    sp_ram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural single-port RAM: registered read, data valid the cycle after the strobe.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_write_en) mem[bus.ram_addr_w] <= bus.ram_data_in;
        if (bus.ram_read_en)  bus.ram_data_out    <= mem[bus.ram_addr_r];
    end

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] model_q[$];
    int            n_wr, n_rd, n_push, n_pop;
    logic          held_vld;
    logic [DW-1:0] held_dat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        model_q.delete();
        n_wr = 0; n_rd = 0; n_push = 0; n_pop = 0;
        held_vld = 1'b0;
        held_dat = '0;
    endtask

    // Mid-cycle checks against the queue model, then commit this cycle's handshakes.
    task automatic sample();
        logic wen, ren;
        wen = bus.ram_write_en;
        ren = bus.ram_read_en;
        check("mutex", 32'(wen & ren), 0);
        check("count", 32'(bus.count), 32'(model_q.size()));
        check("data_in", 32'(bus.ram_data_in), 32'(bus.wr_dat));
        if (model_q.size() == DEPTH + 2) check("full_rdy", 32'(bus.wr_rdy), 0);
        if (model_q.size() == 0) begin
            check("empty_vld", 32'(bus.rd_vld), 0);
            check("empty_ren", 32'(ren), 0);
        end
        if (held_vld) begin
            check("hold_vld", 32'(bus.rd_vld), 1);
            check("hold_dat", 32'(bus.rd_dat), 32'(held_dat));
        end
        if (wen) begin
            check("addr_w", 32'(bus.ram_addr_w), 32'(n_wr % DEPTH));
            n_wr++;
        end
        if (ren) begin
            check("addr_r", 32'(bus.ram_addr_r), 32'(n_rd % DEPTH));
            n_rd++;
        end
        if (bus.rd_vld && bus.rd_rdy) begin
            if (model_q.size() == 0) check("pop_empty", 32'(bus.rd_vld), 0);
            else check("pop_data", 32'(bus.rd_dat), 32'(model_q.pop_front()));
            n_pop++;
        end
        if (bus.wr_vld && bus.wr_rdy) begin
            model_q.push_back(bus.wr_dat);
            n_push++;
        end
        held_vld = bus.rd_vld && !bus.rd_rdy;
        held_dat = bus.rd_dat;
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        clear_model();
        repeat (cycles) begin
            bus.wr_vld = 1'($urandom);
            bus.rd_rdy = 1'($urandom);
            bus.wr_dat = DW'($urandom);
            @(negedge clk);
            check("rst_rd_vld", 32'(bus.rd_vld), 0);
            check("rst_rd_dat", 32'(bus.rd_dat), 0);
            check("rst_count", 32'(bus.count), 0);
            check("rst_ren", 32'(bus.ram_read_en), 0);
            check("rst_addr_r", 32'(bus.ram_addr_r), 0);
            check("rst_addr_w", 32'(bus.ram_addr_w), 0);
            @(posedge clk);
            #1;
        end
        bus.wr_vld = 1'b0;
        bus.rd_rdy = 1'b0;
        #1;
        check("rst_wen", 32'(bus.ram_write_en), 0);
        rst_n = 1'b1;
        #1;
        check("rst_wr_rdy", 32'(bus.wr_rdy), 1);
    endtask

    initial begin
        int idx, acc, wr_pct, rd_pct;
        bus.wr_vld = 1'b0;
        bus.rd_rdy = 1'b0;
        bus.wr_dat = '0;
        clear_model();

        // Reset with random inputs.
        do_reset(4);

        // Single word: write at cycle 0, read at cycle 1, head valid at cycle 3.
        bus.wr_vld = 1'b1;
        bus.wr_dat = 8'hA5;
        @(negedge clk);
        check("sw_wen", 32'(bus.ram_write_en), 1);
        check("sw_addr_w", 32'(bus.ram_addr_w), 0);
        sample();
        @(posedge clk); #1;
        bus.wr_vld = 1'b0;
        @(negedge clk);
        check("sw_ren", 32'(bus.ram_read_en), 1);
        check("sw_addr_r", 32'(bus.ram_addr_r), 0);
        check("sw_count1", 32'(bus.count), 1);
        sample();
        @(posedge clk); #1;
        @(negedge clk);
        check("sw_vld_c2", 32'(bus.rd_vld), 0);
        check("sw_count2", 32'(bus.count), 1);
        sample();
        @(posedge clk); #1;
        @(negedge clk);
        check("sw_vld_c3", 32'(bus.rd_vld), 1);
        check("sw_dat_c3", 32'(bus.rd_dat), 32'h A5);
        check("sw_count3", 32'(bus.count), 1);
        sample();
        @(posedge clk); #1;
        bus.rd_rdy = 1'b1;
        step();
        bus.rd_rdy = 1'b0;
        @(negedge clk);
        check("sw_count_end", 32'(bus.count), 0);
        sample();
        @(posedge clk); #1;

        // Fill with no pops: only DEPTH + 2 words fit, then drain in order.
        do_reset(2);
        idx = 0;
        acc = 0;
        bus.wr_vld = 1'b1;
        bus.wr_dat = '0;
        repeat (20) begin
            @(negedge clk);
            if (bus.wr_vld && bus.wr_rdy) begin
                acc++;
                idx++;
            end
            sample();
            @(posedge clk); #1;
            bus.wr_vld = (idx < 10);
            bus.wr_dat = DW'(idx);
        end
        @(negedge clk);
        check("fill_accepted", 32'(acc), 6);
        check("fill_count", 32'(bus.count), 6);
        check("fill_wr_rdy", 32'(bus.wr_rdy), 0);
        check("fill_rd_dat", 32'(bus.rd_dat), 0);
        sample();
        @(posedge clk); #1;
        bus.wr_vld = 1'b0;
        bus.rd_rdy = 1'b1;
        for (int i = 0; i < 60 && model_q.size() != 0; i++) step();
        check("fill_drained", 32'(model_q.size()), 0);
        check("fill_pops", 32'(n_pop), 6);
        bus.rd_rdy = 1'b0;

        // Random traffic with varying push/pop pressure.
        do_reset(2);
        for (int c = 0; c < 10000; c++) begin
            wr_pct = ((c / 500) % 3 == 0) ? 25 : ((c / 500) % 3 == 1) ? 50 : 90;
            rd_pct = ((c / 700) % 3 == 0) ? 90 : ((c / 700) % 3 == 1) ? 50 : 20;
            bus.wr_vld = ($urandom_range(0, 99) < wr_pct);
            bus.rd_rdy = ($urandom_range(0, 99) < rd_pct);
            bus.wr_dat = DW'($urandom);
            step();
        end
        bus.wr_vld = 1'b0;
        bus.rd_rdy = 1'b1;
        for (int i = 0; i < 60 && model_q.size() != 0; i++) step();
        check("rand_drained", 32'(model_q.size()), 0);
        bus.rd_rdy = 1'b0;

        // Wrap: 3*DEPTH words with alternating push and pop.
        do_reset(2);
        for (int i = 0; i < 400 && n_pop < 3 * DEPTH; i++) begin
            bus.wr_vld = (i % 2 == 0) && (n_push < 3 * DEPTH);
            bus.rd_rdy = (i % 2 == 1);
            bus.wr_dat = DW'($urandom);
            step();
        end
        check("wrap_push", 32'(n_push), 3 * DEPTH);
        check("wrap_pop", 32'(n_pop), 3 * DEPTH);
        check("wrap_writes", 32'(n_wr), 3 * DEPTH);
        check("wrap_reads", 32'(n_rd), 3 * DEPTH);
        bus.wr_vld = 1'b0;
        bus.rd_rdy = 1'b0;

        // Reset in the middle of a burst, then only new data comes out.
        do_reset(2);
        bus.wr_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_dat = DW'(8'h10 + i);
            step();
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(bus.count), 0);
        check("mid_rst_vld", 32'(bus.rd_vld), 0);
        clear_model();
        bus.wr_vld = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.wr_vld = 1'b1;
        bus.wr_dat = 8'h3C;
        step();
        bus.wr_vld = 1'b0;
        step();
        step();
        @(negedge clk);
        check("mid_new_vld", 32'(bus.rd_vld), 1);
        check("mid_new_dat", 32'(bus.rd_dat), 32'h3C);
        sample();
        @(posedge clk); #1;
        bus.rd_rdy = 1'b1;
        repeat (4) step();
        check("mid_pops", 32'(n_pop), 1);
        bus.rd_rdy = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
